// File: rtl/des_pkg.sv
// Shared types and widths for the DES substitution stage.
package des_pkg;

  localparam int unsigned NUM_BOXES = 8;
  localparam int unsigned CHUNK_W   = 6;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned PRE_W     = 48;
  localparam int unsigned POST_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sbox_state_t;

endpackage

// File: rtl/sbox_lut.sv
// Combinational DES S-box lookup; one of eight standard tables selected by box_sel.
module sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]          box_sel,
  input  logic [CHUNK_W-1:0]  in_6bit,
  output logic [NIBBLE_W-1:0] out_4bit
);

  // Each table is rows 0..3 concatenated, row-major, column 0 in the top nibble.
  localparam logic [255:0] S1_TBL = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                     64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
  localparam logic [255:0] S2_TBL = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                     64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
  localparam logic [255:0] S3_TBL = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                     64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
  localparam logic [255:0] S4_TBL = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                     64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
  localparam logic [255:0] S5_TBL = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                     64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
  localparam logic [255:0] S6_TBL = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                     64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
  localparam logic [255:0] S7_TBL = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                     64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  localparam logic [255:0] S8_TBL = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                     64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  logic [255:0] tbl;
  logic [5:0]   idx;

  always_comb begin
    tbl = '0;
    case (box_sel)
      3'd0:    tbl = S1_TBL;
      3'd1:    tbl = S2_TBL;
      3'd2:    tbl = S3_TBL;
      3'd3:    tbl = S4_TBL;
      3'd4:    tbl = S5_TBL;
      3'd5:    tbl = S6_TBL;
      3'd6:    tbl = S7_TBL;
      3'd7:    tbl = S8_TBL;
      default: tbl = '0;
    endcase
  end

  // Entry n sits at bits [255-4n -: 4], i.e. low bit 4*(63-n) = 4*~n.
  always_comb begin
    idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    out_4bit = tbl[{~idx, 2'b00} +: 4];
  end

endmodule

// File: rtl/sbox_sequencer.sv
// DES substitution stage: eight 6-bit chunks walked through one shared S-box, one per clock.
module sbox_sequencer
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PRE_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POST_W-1:0] out_data,
  output logic              busy
);

  sbox_state_t         state_q, state_d;
  logic [PRE_W-1:0]    word_q, word_d;
  logic [2:0]          box_idx_q, box_idx_d;
  logic [POST_W-1:0]   acc_q, acc_d;
  logic [CHUNK_W-1:0]  chunk;
  logic [NIBBLE_W-1:0] nibble;

  always_comb begin
    chunk = '0;
    for (int unsigned b = 0; b < NUM_BOXES; b++) begin
      if (box_idx_q == 3'(b)) chunk = word_q[PRE_W-1-CHUNK_W*b -: CHUNK_W];
    end
  end

  sbox_lut u_lut (
    .box_sel  (box_idx_q),
    .in_6bit  (chunk),
    .out_4bit (nibble)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    box_idx_d = box_idx_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        acc_d = {acc_q[POST_W-NIBBLE_W-1:0], nibble};
        if (box_idx_q == 3'(NUM_BOXES-1)) state_d = DONE;
        else                              box_idx_d = box_idx_q + 3'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load from IDLE or from DONE (overlapped with the output transfer).
    if (in_ready && in_valid) begin
      word_d    = in_data;
      box_idx_d = '0;
      acc_d     = '0;
      state_d   = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      box_idx_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      box_idx_q <= box_idx_d;
      acc_q     <= acc_d;
    end
  end

  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_sequencer.sv
// Scoreboard bench for sbox_sequencer: driver queues expected results, monitor checks outputs.
module tb_sbox_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  sbox_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          rise;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   have_cur   = 1'b0;
  exp_t cur;

  localparam logic [47:0] V_ZERO = 48'h0;
  localparam logic [47:0] V_ONES = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] V_RND1 = 48'h6117BA866527;
  localparam logic [31:0] R_ZERO = 32'hEFA72C4D;
  localparam logic [31:0] R_ONES = 32'hD9CE3DCB;
  localparam logic [31:0] R_RND1 = 32'h5C82B597;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge, after the driver has settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        have_cur = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_output: got %0h, expected no output (cycle %0d)", out_data, cyc);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            chk("latency_rise_cycle", 64'(cyc), 64'(cur.rise));
          end
        end
        if (have_cur) begin
          chk("out_data", 64'(out_data), 64'(cur.data));
          if (out_ready) have_cur = 1'b0;
        end
      end else if (have_cur) begin
        chk("out_valid_held", 64'(out_valid), 64'd1);
        have_cur = 1'b0;
      end
    end
  end

  task automatic send(input logic [47:0] d, input logic [31:0] e);
    bit ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back('{data: e, rise: cyc + 9});
        ok = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready never seen for %0h", d);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Single words with out_ready held high.
    send(V_ZERO, R_ZERO);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    repeat (12) @(negedge clk);
    send(V_ONES, R_ONES);
    repeat (12) @(negedge clk);
    send(V_RND1, R_RND1);
    repeat (12) @(negedge clk);

    // Output backpressure for 5 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    send(V_ONES, R_ONES);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = out_valid;
    end
    chk("bp_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_follows", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    chk("bp_single_transfer", 64'(out_valid), 64'd0);
    chk("bp_back_to_idle", 64'(busy), 64'd0);

    // Back-to-back: each accept overlaps the previous DONE cycle.
    send(V_ZERO, R_ZERO);
    send(V_ONES, R_ONES);
    send(V_RND1, R_RND1);
    repeat (14) @(negedge clk);

    // Reset while box_idx = 4.
    send(V_RND1, R_RND1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_out_data", 64'(out_data), 64'd0);
    repeat (20) @(negedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("no_pending_output", 64'(have_cur), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
